// File: rtl/raifes_qspi_target.sv
// QSPI/QPI memory-target responder. It oversamples SCK/nCS/IO on iClk and maps
// WREN, WRCR, QPIEN, READ and WRITE traffic onto a byte-wide synchronous memory port.
module raifes_qspi_target #(
   parameter int unsigned ADDR_BITS  = 16,
   parameter int unsigned DUMMY_CLKS = 1,
   parameter logic [7:0]  CFG_RESET  = 8'h00
) (
   input  logic                 iClk,
   input  logic                 iReset,
   input  logic                 iSCK,
   input  logic                 iNCS,
   input  logic [3:0]           iIO_In,
   output logic [3:0]           oIO_Out,
   output logic [3:0]           oIO_En,
   output logic                 oNHSB,
   output logic [ADDR_BITS-1:0] oMem_Addr,
   output logic [7:0]           oMem_WData,
   output logic                 oMem_WE,
   output logic                 oMem_RE,
   input  logic [7:0]           iMem_RData,
   output logic [7:0]           oCfg,
   output logic                 oQPI,
   output logic                 oWEL
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_CFG,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   localparam logic [4:0] DUMMY_LAST = 5'((DUMMY_CLKS == 0) ? 0 : DUMMY_CLKS - 1);

   // Bit [1] is the synchronised level, bit [2] the previous one for edge detection.
   logic [2:0] sck_sync_q;
   logic [2:0] ncs_sync_q;
   logic [3:0] io_s1_q;
   logic [3:0] io_s2_q;

   state_t                 state_q,   state_d;
   logic [4:0]             cnt_q,     cnt_d;
   logic [23:0]            sh_q,      sh_d;
   logic [7:0]             tx_q,      tx_d;
   logic [ADDR_BITS-1:0]   addr_q,    addr_d;
   logic [7:0]             wdata_q,   wdata_d;
   logic                   we_q,      we_d;
   logic                   re_q,      re_d;
   logic                   rd_lat_q,  rd_lat_d;
   logic [3:0]             io_out_q,  io_out_d;
   logic [3:0]             io_en_q,   io_en_d;
   logic [7:0]             cfg_q,     cfg_d;
   logic                   qpi_q,     qpi_d;
   logic                   wel_q,     wel_d;
   logic                   is_read_q, is_read_d;
   logic                   clr_wel_q, clr_wel_d;

   logic        sck_rise;
   logic        sck_fall;
   logic        ncs_fall;
   logic        ncs_rise;
   logic [4:0]  step;
   logic [4:0]  cnt_inc;
   logic [23:0] sh_shift;

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         sck_sync_q <= 3'b000;
         ncs_sync_q <= 3'b111;
         io_s1_q    <= 4'h0;
         io_s2_q    <= 4'h0;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], iSCK};
         ncs_sync_q <= {ncs_sync_q[1:0], iNCS};
         io_s1_q    <= iIO_In;
         io_s2_q    <= io_s1_q;
      end
   end

   // SCK edges only count while the synchronised chip select is low.
   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2] & ~ncs_sync_q[1];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2] & ~ncs_sync_q[1];
   assign ncs_fall = ~ncs_sync_q[1] & ncs_sync_q[2];
   assign ncs_rise = ncs_sync_q[1] & ~ncs_sync_q[2];

   assign step     = qpi_q ? 5'd4 : 5'd1;
   assign cnt_inc  = cnt_q + step;
   assign sh_shift = qpi_q ? {sh_q[19:0], io_s2_q} : {sh_q[22:0], io_s2_q[0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      tx_d      = tx_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      rd_lat_d  = re_q;
      io_out_d  = io_out_q;
      io_en_d   = io_en_q;
      cfg_d     = cfg_q;
      qpi_d     = qpi_q;
      wel_d     = wel_q;
      is_read_d = is_read_q;
      clr_wel_d = clr_wel_q;

      // The write address advances on the cycle after the strobe has been seen.
      if (we_q) begin
         addr_d = addr_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (ncs_fall) begin
               state_d   = ST_CMD;
               cnt_d     = 5'd0;
               is_read_d = 1'b0;
               clr_wel_d = 1'b0;
            end
         end
         ST_CMD: begin
            if (sck_rise) begin
               sh_d  = sh_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == 5'd8) begin
                  cnt_d = 5'd0;
                  unique case (sh_shift[7:0])
                     8'h06: begin
                        wel_d   = 1'b1;
                        state_d = ST_IGNORE;
                     end
                     8'h38: begin
                        qpi_d   = 1'b1;
                        state_d = ST_IGNORE;
                     end
                     8'h87: begin
                        clr_wel_d = 1'b1;
                        state_d   = ST_CFG;
                     end
                     8'h03: begin
                        is_read_d = 1'b1;
                        state_d   = ST_ADDR;
                     end
                     8'h02: begin
                        clr_wel_d = 1'b1;
                        state_d   = ST_ADDR;
                     end
                     default: state_d = ST_IGNORE;
                  endcase
               end
            end
         end
         ST_CFG: begin
            if (sck_rise) begin
               sh_d  = sh_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == 5'd8) begin
                  cnt_d = 5'd0;
                  if (wel_q) begin
                     cfg_d = sh_shift[7:0];
                  end
                  state_d = ST_IGNORE;
               end
            end
         end
         ST_ADDR: begin
            if (sck_rise) begin
               sh_d  = sh_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == 5'd24) begin
                  cnt_d  = 5'd0;
                  addr_d = sh_shift[ADDR_BITS-1:0];
                  if (is_read_q) begin
                     re_d    = 1'b1;
                     state_d = (DUMMY_CLKS == 0) ? ST_RDATA : ST_DUMMY;
                  end else begin
                     state_d = ST_WDATA;
                  end
               end
            end
         end
         ST_DUMMY: begin
            if (sck_rise) begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == DUMMY_LAST) begin
                  cnt_d   = 5'd0;
                  state_d = ST_RDATA;
               end
            end
         end
         ST_RDATA: begin
            if (sck_fall) begin
               cnt_d = cnt_inc;
               if (qpi_q) begin
                  io_en_d  = 4'hF;
                  io_out_d = tx_q[7:4];
                  tx_d     = {tx_q[3:0], 4'h0};
               end else begin
                  io_en_d  = 4'b0010;
                  io_out_d = {2'b00, tx_q[7], 1'b0};
                  tx_d     = {tx_q[6:0], 1'b0};
               end
               // Last nibble/bit of the byte is on the wire: prefetch the next byte.
               if (cnt_inc == 5'd8) begin
                  cnt_d  = 5'd0;
                  addr_d = addr_q + 1'b1;
                  re_d   = 1'b1;
               end
            end
         end
         ST_WDATA: begin
            if (sck_rise) begin
               sh_d  = sh_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == 5'd8) begin
                  cnt_d = 5'd0;
                  if (wel_q) begin
                     we_d    = 1'b1;
                     wdata_d = sh_shift[7:0];
                  end
               end
            end
         end
         ST_IGNORE: begin
         end
         default: state_d = ST_IDLE;
      endcase

      if (rd_lat_q) begin
         tx_d = iMem_RData;
      end

      // End of transaction; an already-issued write strobe is left to complete.
      if (ncs_rise) begin
         state_d   = ST_IDLE;
         cnt_d     = 5'd0;
         io_en_d   = 4'h0;
         io_out_d  = 4'h0;
         is_read_d = 1'b0;
         clr_wel_d = 1'b0;
         if (clr_wel_q) begin
            wel_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 5'd0;
         sh_q      <= 24'h0;
         tx_q      <= 8'h00;
         addr_q    <= '0;
         wdata_q   <= 8'h00;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         rd_lat_q  <= 1'b0;
         io_out_q  <= 4'h0;
         io_en_q   <= 4'h0;
         cfg_q     <= CFG_RESET;
         qpi_q     <= 1'b0;
         wel_q     <= 1'b0;
         is_read_q <= 1'b0;
         clr_wel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         tx_q      <= tx_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         re_q      <= re_d;
         rd_lat_q  <= rd_lat_d;
         io_out_q  <= io_out_d;
         io_en_q   <= io_en_d;
         cfg_q     <= cfg_d;
         qpi_q     <= qpi_d;
         wel_q     <= wel_d;
         is_read_q <= is_read_d;
         clr_wel_q <= clr_wel_d;
      end
   end

   assign oIO_Out    = io_out_q;
   assign oIO_En     = io_en_q;
   assign oNHSB      = 1'b1;
   assign oMem_Addr  = addr_q;
   assign oMem_WData = wdata_q;
   assign oMem_WE    = we_q;
   assign oMem_RE    = re_q;
   assign oCfg       = cfg_q;
   assign oQPI       = qpi_q;
   assign oWEL       = wel_q;

endmodule

// File: tb/tb_raifes_qspi_target.sv
// Bench for raifes_qspi_target: a host model drives SPI/QPI transactions, a reference
// model predicts memory-port and read-data events, and monitors pop and compare them.
module tb_raifes_qspi_target;

   localparam int         H       = 6;
   localparam logic [7:0] CFG_RST = 8'h00;

   logic        iClk   = 1'b0;
   logic        iReset = 1'b1;
   logic        iSCK   = 1'b0;
   logic        iNCS   = 1'b1;
   logic [3:0]  iIO_In = 4'h0;
   logic [3:0]  oIO_Out;
   logic [3:0]  oIO_En;
   logic        oNHSB;
   logic [15:0] oMem_Addr;
   logic [7:0]  oMem_WData;
   logic        oMem_WE;
   logic        oMem_RE;
   logic [7:0]  iMem_RData;
   logic [7:0]  oCfg;
   logic        oQPI;
   logic        oWEL;

   raifes_qspi_target #(
      .ADDR_BITS (16),
      .DUMMY_CLKS(1),
      .CFG_RESET (CFG_RST)
   ) dut (
      .iClk      (iClk),
      .iReset    (iReset),
      .iSCK      (iSCK),
      .iNCS      (iNCS),
      .iIO_In    (iIO_In),
      .oIO_Out   (oIO_Out),
      .oIO_En    (oIO_En),
      .oNHSB     (oNHSB),
      .oMem_Addr (oMem_Addr),
      .oMem_WData(oMem_WData),
      .oMem_WE   (oMem_WE),
      .oMem_RE   (oMem_RE),
      .iMem_RData(iMem_RData),
      .oCfg      (oCfg),
      .oQPI      (oQPI),
      .oWEL      (oWEL)
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } we_t;

   typedef struct packed {
      logic       qpi;
      logic [3:0] val;
   } rd_t;

   we_t         exp_we[$];
   logic [15:0] exp_re[$];
   rd_t         exp_rd[$];

   logic [7:0] phys_mem [0:65535];
   logic [7:0] ref_mem  [0:65535];
   logic       mem_load = 1'b0;
   logic [7:0] wbuf     [0:7];

   logic       m_wel;
   logic       m_qpi;
   logic [7:0] m_cfg;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 iClk = ~iClk;

   // Byte-wide synchronous memory attached to the target.
   always @(posedge iClk) begin
      if (mem_load) begin
         for (int i = 0; i < 65536; i++) phys_mem[i] <= ref_mem[i];
      end else begin
         if (oMem_RE) iMem_RData <= phys_mem[oMem_Addr];
         if (oMem_WE) phys_mem[oMem_Addr] <= oMem_WData;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event with value 0x%0h, required none", nm, act);
   endtask

   task automatic mon_mem();
      we_t         e;
      logic [15:0] a;
      forever begin
         @(negedge iClk);
         if (iReset == 1'b0) begin
            if (oMem_WE === 1'b1) begin
               if (exp_we.size() == 0) unexpected("we_unexpected", 32'(oMem_Addr));
               else begin
                  e = exp_we.pop_front();
                  check("we_addr", 32'(oMem_Addr), 32'(e.addr));
                  check("we_data", 32'(oMem_WData), 32'(e.data));
               end
            end
            if (oMem_RE === 1'b1) begin
               if (exp_re.size() == 0) unexpected("re_unexpected", 32'(oMem_Addr));
               else begin
                  a = exp_re.pop_front();
                  check("re_addr", 32'(oMem_Addr), 32'(a));
               end
            end
         end
      end
   endtask

   task automatic mon_rd();
      rd_t r;
      forever begin
         @(posedge iSCK);
         if (!iReset && !iNCS && oIO_En != 4'h0) begin
            if (exp_rd.size() == 0) unexpected("rd_unexpected", 32'(oIO_En));
            else begin
               r = exp_rd.pop_front();
               if (r.qpi) begin
                  check("rd_en_qpi", 32'(oIO_En), 32'hF);
                  check("rd_nibble", 32'(oIO_Out), 32'(r.val));
               end else begin
                  check("rd_en_spi", 32'(oIO_En), 32'h2);
                  check("rd_bit", 32'(oIO_Out[1]), 32'(r.val[0]));
               end
            end
         end
      end
   endtask

   // Host drives IO while SCK is low; the target samples on the rise.
   task automatic sck_cycle(input logic [3:0] d);
      iIO_In = d;
      repeat (H) @(negedge iClk);
      iSCK = 1'b1;
      repeat (H) @(negedge iClk);
      iSCK = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      if (m_qpi) begin
         sck_cycle(b[7:4]);
         sck_cycle(b[3:0]);
      end else begin
         for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]});
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic cs_low();
      iNCS = 1'b0;
      repeat (H) @(negedge iClk);
   endtask

   task automatic cs_high();
      repeat (H) @(negedge iClk);
      iNCS   = 1'b1;
      iIO_In = 4'h0;
      repeat (3 * H) @(negedge iClk);
   endtask

   task automatic post_check();
      check("wel", 32'(oWEL), 32'(m_wel));
      check("cfg", 32'(oCfg), 32'(m_cfg));
      check("qpi", 32'(oQPI), 32'(m_qpi));
      check("io_en_idle", 32'(oIO_En), 32'h0);
   endtask

   task automatic do_simple(input logic [7:0] op);
      $display("[TB] CMD op=%02h qpi=%0d", op, m_qpi);
      cs_low();
      send_byte(op);
      cs_high();
      if (op == 8'h06) m_wel = 1'b1;
      if (op == 8'h38) m_qpi = 1'b1;
      post_check();
   endtask

   task automatic do_wrcr(input logic [7:0] b);
      $display("[TB] WRCR data=%02h qpi=%0d wel=%0d", b, m_qpi, m_wel);
      cs_low();
      send_byte(8'h87);
      send_byte(b);
      cs_high();
      if (m_wel) m_cfg = b;
      m_wel = 1'b0;
      post_check();
   endtask

   task automatic do_write(input logic [23:0] a, input int n);
      logic [15:0] ad;
      ad = a[15:0];
      $display("[TB] WRITE addr=%06h len=%0d qpi=%0d wel=%0d", a, n, m_qpi, m_wel);
      for (int i = 0; i < n; i++) begin
         if (m_wel) begin
            exp_we.push_back('{addr: 16'(ad + 16'(i)), data: wbuf[i]});
            ref_mem[16'(ad + 16'(i))] = wbuf[i];
         end
      end
      cs_low();
      send_byte(8'h02);
      send_addr(a);
      for (int i = 0; i < n; i++) send_byte(wbuf[i]);
      cs_high();
      m_wel = 1'b0;
      post_check();
   endtask

   task automatic do_write_abort(input logic [23:0] a);
      $display("[TB] WRITE-ABORT addr=%06h qpi=%0d wel=%0d", a, m_qpi, m_wel);
      cs_low();
      send_byte(8'h02);
      send_addr(a);
      sck_cycle(4'hC);
      cs_high();
      m_wel = 1'b0;
      post_check();
   endtask

   // abort_clks >= 0 stops after that many data clocks with nCS still low.
   task automatic do_read(input logic [23:0] a, input int n, input int abort_clks);
      logic [15:0] ad;
      logic [7:0]  b;
      ad = a[15:0];
      $display("[TB] READ addr=%06h len=%0d qpi=%0d abort=%0d", a, n, m_qpi, abort_clks);
      for (int i = 0; i <= n; i++) exp_re.push_back(16'(ad + 16'(i)));
      for (int i = 0; i < n; i++) begin
         b = ref_mem[16'(ad + 16'(i))];
         if (m_qpi) begin
            exp_rd.push_back('{qpi: 1'b1, val: b[7:4]});
            exp_rd.push_back('{qpi: 1'b1, val: b[3:0]});
         end else begin
            for (int j = 7; j >= 0; j--) exp_rd.push_back('{qpi: 1'b0, val: {3'b000, b[j]}});
         end
      end
      cs_low();
      send_byte(8'h03);
      send_addr(a);
      sck_cycle(4'h0);
      if (abort_clks >= 0) begin
         repeat (abort_clks) sck_cycle(4'h0);
      end else begin
         repeat (n * (m_qpi ? 2 : 8)) sck_cycle(4'h0);
         cs_high();
         post_check();
      end
   endtask

   initial begin
      int r;
      int len;
      logic [23:0] ra;

      fork
         mon_mem();
         mon_rd();
      join_none

      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
      mem_load = 1'b1;
      repeat (2) @(negedge iClk);
      mem_load = 1'b0;
      m_wel = 1'b0;
      m_qpi = 1'b0;
      m_cfg = CFG_RST;

      check("rst_io_out", 32'(oIO_Out), 32'h0);
      check("rst_io_en", 32'(oIO_En), 32'h0);
      check("rst_we", 32'(oMem_WE), 32'h0);
      check("rst_re", 32'(oMem_RE), 32'h0);
      check("rst_addr", 32'(oMem_Addr), 32'h0);
      check("rst_cfg", 32'(oCfg), 32'(CFG_RST));
      check("rst_qpi", 32'(oQPI), 32'h0);
      check("rst_wel", 32'(oWEL), 32'h0);
      check("nhsb", 32'(oNHSB), 32'h1);
      iReset = 1'b0;
      repeat (4) @(negedge iClk);

      do_simple(8'h06);
      do_wrcr(8'h42);
      do_wrcr(8'h17);
      do_simple(8'h38);
      do_simple(8'h06);
      wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
      do_write(24'h000010, 4);
      do_read(24'h000010, 4, -1);
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(24'h000020, 2);
      do_simple(8'h06);
      wbuf[0] = 8'h5A; wbuf[1] = 8'hA5;
      do_write(24'h00FFFF, 2);
      do_read(24'h00FFFF, 2, -1);
      do_simple(8'h06);
      do_write_abort(24'h000040);
      do_read(24'h000040, 1, -1);

      do_read(24'h000010, 4, 3);
      @(negedge iClk);
      #1 iReset = 1'b1;
      #1;
      $display("[TB] RESET mid-read");
      check("rst_mid_io_en", 32'(oIO_En), 32'h0);
      check("rst_mid_qpi", 32'(oQPI), 32'h0);
      check("rst_mid_cfg", 32'(oCfg), 32'(CFG_RST));
      check("rst_mid_re", 32'(oMem_RE), 32'h0);
      check("rst_mid_addr", 32'(oMem_Addr), 32'h0);
      exp_rd.delete();
      exp_re.delete();
      iNCS   = 1'b1;
      iIO_In = 4'h0;
      m_wel  = 1'b0;
      m_qpi  = 1'b0;
      m_cfg  = CFG_RST;
      repeat (3) @(negedge iClk);
      iReset = 1'b0;
      repeat (4) @(negedge iClk);

      for (int k = 0; k < 24; k++) begin
         r   = int'($urandom_range(0, 9));
         ra  = 24'($urandom);
         len = int'($urandom_range(1, 4));
         if (r <= 1) begin
            do_simple(8'h06);
         end else if (r == 2) begin
            if ($urandom_range(0, 1) == 1) do_simple(8'h06);
            do_wrcr(8'($urandom));
         end else if (r <= 5) begin
            if ($urandom_range(0, 9) < 7) do_simple(8'h06);
            for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
            do_write(ra, len);
         end else if (r <= 8 || k < 12) begin
            do_read(ra, len, -1);
         end else begin
            do_simple(8'h38);
         end
      end

      repeat (20) @(negedge iClk);
      check("we_left", 32'(exp_we.size()), 32'h0);
      check("re_left", 32'(exp_re.size()), 32'h0);
      check("rd_left", 32'(exp_rd.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
